// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the pipeline (fetch + load/store), the arbiter and the unified RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              stall_load;
    logic              stall_store;
    logic              stall_fetch;

    modport slave (
        input  if_req, if_addr, if_flush, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        output if_ready, if_rdata, mem_ready, mem_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output stall_load, stall_store, stall_fetch
    );

    modport master (
        output if_req, if_addr, if_flush, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        input  if_ready, if_rdata, mem_ready, mem_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  stall_load, stall_store, stall_fetch
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported RAM between fetch and load/store; data wins, no pre-emption.
// Ready pulses MEM_LAT+1 cycles after a request is seen in IDLE; waiting requesters see their stall held high.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int              CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_MEM,
        BUSY_IF,
        DONE_MEM,
        DONE_IF
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  cnt;
    logic              flushFlag;
    logic              opWrite;
    logic [ADDR_W-1:0] addrLat;
    logic [DATA_W-1:0] wdataLat;
    logic [DATA_W-1:0] ifRdataQ;
    logic [DATA_W-1:0] memRdataQ;

    logic              ramBusy;
    logic              ramWrite;
    logic              ifReady;
    logic              memReady;

    always_comb begin
        stateNext = state;
        ramBusy   = 1'b0;
        ramWrite  = 1'b0;
        ifReady   = 1'b0;
        memReady  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_rd | bus.mem_wr) begin
                    stateNext = BUSY_MEM;
                end else if (bus.if_req) begin
                    stateNext = BUSY_IF;
                end
            end
            BUSY_MEM: begin
                ramBusy  = 1'b1;
                ramWrite = opWrite;
                if (cnt == '0) begin
                    stateNext = DONE_MEM;
                end
            end
            BUSY_IF: begin
                ramBusy = 1'b1;
                if (cnt == '0) begin
                    stateNext = DONE_IF;
                end
            end
            DONE_MEM: begin
                memReady  = 1'b1;
                stateNext = IDLE;
            end
            DONE_IF: begin
                // A flush arriving in the delivery cycle itself must also cancel the pulse.
                ifReady   = ~flushFlag & ~bus.if_flush;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            flushFlag <= 1'b0;
            opWrite   <= 1'b0;
            addrLat   <= '0;
            wdataLat  <= '0;
            ifRdataQ  <= '0;
            memRdataQ <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (bus.mem_rd | bus.mem_wr) begin
                        opWrite  <= bus.mem_wr;
                        addrLat  <= bus.mem_addr;
                        wdataLat <= bus.mem_wdata;
                        cnt      <= CNT_INIT;
                    end else if (bus.if_req) begin
                        opWrite   <= 1'b0;
                        addrLat   <= bus.if_addr;
                        flushFlag <= 1'b0;
                        cnt       <= CNT_INIT;
                    end
                end
                BUSY_MEM: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        memRdataQ <= bus.ram_rdata;
                    end
                end
                BUSY_IF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ifRdataQ <= bus.ram_rdata;
                    end
                    if (bus.if_flush) begin
                        flushFlag <= 1'b1;
                    end
                end
                DONE_IF: begin
                    if (bus.if_flush) begin
                        flushFlag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_en    = ramBusy;
    assign bus.ram_we    = ramWrite;
    assign bus.ram_addr  = addrLat;
    assign bus.ram_wdata = wdataLat;
    assign bus.if_ready  = ifReady;
    assign bus.if_rdata  = ifRdataQ;
    assign bus.mem_ready = memReady;
    assign bus.mem_rdata = memRdataQ;

    // Stalls are forced low during reset so the stall unit sees a clean pipeline.
    assign bus.stall_store = ~rst & bus.mem_wr & ~memReady;
    assign bus.stall_load  = ~rst & bus.mem_rd & ~bus.mem_wr & ~memReady;
    assign bus.stall_fetch = ~rst & bus.if_req & ~ifReady;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a timeline model.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    logic [31:0] junk = 32'h0;
    int          tests = 0;
    int          fails = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        junk <= $urandom;
    end

    function automatic logic [31:0] rdataOf(input logic [31:0] a);
        return ((a - 32'h10) * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    // Timeline model: an access accepted in cycle s uses the RAM in s+1..s+L,
    // delivers in s+L+1 and frees the port in s+L+2.
    int          mKind = 0;
    int          mStart = -100;
    int          mFree = 0;
    int          lastBusy = -1;
    bit          mFlushed = 1'b0;
    bit          mStore = 1'b0;
    logic [31:0] mAddr = '0;
    logic [31:0] mWdata = '0;
    logic [31:0] mIfRd = '0;
    logic [31:0] mMemRd = '0;
    logic        eRamEn = 1'b0;
    logic        eRamWe = 1'b0;
    logic        eIfRdy = 1'b0;
    logic        eMemRdy = 1'b0;
    logic [6:0]  eVec = '0;
    logic [6:0]  obs;

    // RAM returns valid data only in the last BUSY cycle; anything else is noise.
    assign bus.ram_rdata = (cyc == lastBusy) ? rdataOf(bus.ram_addr) : junk;
    assign obs = {bus.ram_en, bus.ram_we, bus.if_ready, bus.mem_ready,
                  bus.stall_load, bus.stall_store, bus.stall_fetch};

    task automatic model_step();
        if (rst) begin
            mKind = 0; mStart = -100; mFree = cyc + 1; lastBusy = -1; mFlushed = 1'b0;
            mIfRd = '0; mMemRd = '0;
            eRamEn = 1'b0; eRamWe = 1'b0; eIfRdy = 1'b0; eMemRdy = 1'b0; eVec = '0;
            return;
        end
        if (mKind == 1 && cyc == mStart + L + 1) mMemRd = rdataOf(mAddr);
        if (mKind == 2 && cyc == mStart + L + 1) mIfRd = rdataOf(mAddr);
        if (mKind == 2 && cyc > mStart && cyc <= mStart + L + 1 && bus.if_flush) mFlushed = 1'b1;
        eRamEn  = (mKind != 0) && cyc > mStart && cyc <= mStart + L;
        eRamWe  = eRamEn && mKind == 1 && mStore;
        eMemRdy = (mKind == 1) && cyc == mStart + L + 1;
        eIfRdy  = (mKind == 2) && cyc == mStart + L + 1 && !mFlushed;
        eVec = {eRamEn, eRamWe, eIfRdy, eMemRdy,
                bus.mem_rd & ~bus.mem_wr & ~eMemRdy, bus.mem_wr & ~eMemRdy, bus.if_req & ~eIfRdy};
        if (cyc >= mFree && (bus.mem_rd || bus.mem_wr || bus.if_req)) begin
            mKind    = (bus.mem_rd || bus.mem_wr) ? 1 : 2;
            mStart   = cyc;
            mFree    = cyc + L + 2;
            lastBusy = cyc + L;
            mFlushed = 1'b0;
            mStore   = (mKind == 1) && bus.mem_wr;
            mAddr    = (mKind == 1) ? bus.mem_addr : bus.if_addr;
            mWdata   = bus.mem_wdata;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            next_cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.if_req = 1'b1; bus.mem_rd = 1'b1; bus.mem_wr = 1'b1;
        sample();
        tests++;
        if (obs !== 7'b0) begin
            fails++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0);
        end
        tests++;
        if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got if=%h mem=%h want 0/0", bus.if_rdata, bus.mem_rdata);
        end
        next_cyc();
        rst = 1'b0; bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        sample();
        tests++;
        if (obs !== 7'b0) begin
            fails++; $display("FAIL idle_outputs: got %b want %b", obs, 7'b0);
        end
        next_cyc();
    endtask

    task automatic test_fetch();
        logic want;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) bus.if_req = 1'b0;
            sample();
            want = (c == 1 || c == 2);
            tests++;
            if (bus.ram_en !== want) begin
                fails++; $display("FAIL fetch_ram_en c%0d: got %b want %b", c, bus.ram_en, want);
            end
            tests++;
            if (bus.if_ready !== (c == 3)) begin
                fails++; $display("FAIL fetch_if_ready c%0d: got %b want %b", c, bus.if_ready, c == 3);
            end
            tests++;
            if (bus.stall_fetch !== (c <= 2)) begin
                fails++; $display("FAIL fetch_stall c%0d: got %b want %b", c, bus.stall_fetch, c <= 2);
            end
            if (c == 1) begin
                tests++;
                if (bus.ram_addr !== 32'h10) begin
                    fails++; $display("FAIL fetch_addr: got %h want %h", bus.ram_addr, 32'h10);
                end
            end
            if (c == 3) begin
                tests++;
                if (bus.if_rdata !== 32'hDEADBEEF) begin
                    fails++; $display("FAIL fetch_rdata: got %h want %h", bus.if_rdata, 32'hDEADBEEF);
                end
            end
            next_cyc();
        end
    endtask

    task automatic test_fetch_load();
        logic want;
        bus.if_req = 1'b1; bus.if_addr = 32'h14; bus.mem_rd = 1'b1; bus.mem_addr = 32'h40;
        for (int c = 0; c < 9; c++) begin
            if (c == 4) bus.mem_rd = 1'b0;
            if (c == 8) bus.if_req = 1'b0;
            sample();
            want = (c == 1 || c == 2 || c == 5 || c == 6);
            tests++;
            if ({bus.ram_en, bus.mem_ready, bus.if_ready} !== {want, c == 3, c == 7}) begin
                fails++; $display("FAIL fetch_load_seq c%0d: got en/mrdy/irdy=%b%b%b want %b%b%b",
                                  c, bus.ram_en, bus.mem_ready, bus.if_ready, want, c == 3, c == 7);
            end
            tests++;
            if ({bus.stall_load, bus.stall_fetch} !== {c <= 2, c <= 6}) begin
                fails++; $display("FAIL fetch_load_stall c%0d: got %b%b want %b%b",
                                  c, bus.stall_load, bus.stall_fetch, c <= 2, c <= 6);
            end
            if (c == 3) begin
                tests++;
                if (bus.mem_rdata !== rdataOf(32'h40)) begin
                    fails++; $display("FAIL fetch_load_mrdata: got %h want %h", bus.mem_rdata, rdataOf(32'h40));
                end
            end
            if (c == 7) begin
                tests++;
                if (bus.if_rdata !== rdataOf(32'h14)) begin
                    fails++; $display("FAIL fetch_load_irdata: got %h want %h", bus.if_rdata, rdataOf(32'h14));
                end
            end
            next_cyc();
        end
    endtask

    task automatic test_store();
        logic want;
        for (int v = 0; v < 2; v++) begin
            bus.mem_wr = 1'b1; bus.mem_rd = (v == 1);
            bus.mem_addr = 32'h20 + 32'(4 * v); bus.mem_wdata = 32'h55 + 32'(v);
            for (int c = 0; c < 5; c++) begin
                if (c == 4) begin bus.mem_wr = 1'b0; bus.mem_rd = 1'b0; end
                sample();
                want = (c == 1 || c == 2);
                tests++;
                if ({bus.ram_en, bus.ram_we, bus.mem_ready} !== {want, want, c == 3}) begin
                    fails++; $display("FAIL store_seq v%0d c%0d: got en/we/rdy=%b%b%b want %b%b%b",
                                      v, c, bus.ram_en, bus.ram_we, bus.mem_ready, want, want, c == 3);
                end
                tests++;
                if ({bus.stall_store, bus.stall_load} !== {c <= 2, 1'b0}) begin
                    fails++; $display("FAIL store_stall v%0d c%0d: got st/ld=%b%b want %b0",
                                      v, c, bus.stall_store, bus.stall_load, c <= 2);
                end
                if (want) begin
                    tests++;
                    if (bus.ram_wdata !== 32'h55 + 32'(v) || bus.ram_addr !== 32'h20 + 32'(4 * v)) begin
                        fails++; $display("FAIL store_bus v%0d c%0d: got addr=%h data=%h want %h/%h", v, c,
                                          bus.ram_addr, bus.ram_wdata, 32'h20 + 32'(4 * v), 32'h55 + 32'(v));
                    end
                end
                next_cyc();
            end
        end
    endtask

    task automatic test_flush();
        logic want;
        for (int k = 0; k < 2; k++) begin
            int fc;
            fc = (k == 0) ? 1 : 3;
            bus.if_req = 1'b1; bus.if_addr = 32'h18;
            for (int c = 0; c < 9; c++) begin
                bus.if_flush = (c == fc);
                if (c == fc + 1) bus.if_req = 1'b0;
                if (c == 4) begin bus.mem_rd = 1'b1; bus.mem_addr = 32'h44; end
                if (c == 8) bus.mem_rd = 1'b0;
                sample();
                want = (c == 1 || c == 2 || c == 5 || c == 6);
                tests++;
                if ({bus.ram_en, bus.if_ready, bus.mem_ready} !== {want, 1'b0, c == 7}) begin
                    fails++; $display("FAIL flush_seq f%0d c%0d: got en/irdy/mrdy=%b%b%b want %b0%b",
                                      fc, c, bus.ram_en, bus.if_ready, bus.mem_ready, want, c == 7);
                end
                next_cyc();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic want;
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h48;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                rst = 1'b1;
                #1;
                tests++;
                if ({bus.ram_en, bus.mem_ready} !== 2'b00) begin
                    fails++; $display("FAIL reset_mid_immediate: got en/rdy=%b%b want 00", bus.ram_en, bus.mem_ready);
                end
            end
            if (c == 3) rst = 1'b0;
            if (c == 7) bus.mem_rd = 1'b0;
            sample();
            want = (c == 1 || c == 4 || c == 5);
            tests++;
            if ({bus.ram_en, bus.mem_ready, bus.stall_load} !== {want, c == 6, c != 2 && c <= 5}) begin
                fails++; $display("FAIL reset_mid_seq c%0d: got en/rdy/stl=%b%b%b want %b%b%b", c,
                                  bus.ram_en, bus.mem_ready, bus.stall_load, want, c == 6, c != 2 && c <= 5);
            end
            if (c == 2 || c == 6) begin
                tests++;
                if (bus.mem_rdata !== ((c == 2) ? 32'h0 : rdataOf(32'h48))) begin
                    fails++; $display("FAIL reset_mid_rdata c%0d: got %h want %h", c, bus.mem_rdata,
                                      (c == 2) ? 32'h0 : rdataOf(32'h48));
                end
            end
            next_cyc();
        end
    endtask

    task automatic test_late_load();
        logic want;
        bus.if_req = 1'b1; bus.if_addr = 32'h1C;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) begin bus.mem_rd = 1'b1; bus.mem_addr = 32'h4C; end
            if (c == 4) bus.if_req = 1'b0;
            if (c == 8) bus.mem_rd = 1'b0;
            sample();
            want = (c == 1 || c == 2 || c == 5 || c == 6);
            tests++;
            if ({bus.ram_en, bus.if_ready, bus.mem_ready, bus.stall_load} !==
                {want, c == 3, c == 7, c >= 1 && c <= 6}) begin
                fails++; $display("FAIL late_load_seq c%0d: got en/irdy/mrdy/stl=%b%b%b%b want %b%b%b%b", c,
                                  bus.ram_en, bus.if_ready, bus.mem_ready, bus.stall_load,
                                  want, c == 3, c == 7, c >= 1 && c <= 6);
            end
            next_cyc();
        end
    endtask

    task automatic test_random();
        bit   fetchPend = 1'b0;
        bit   memPend = 1'b0;
        logic sawIf = 1'b0;
        logic sawMem = 1'b0;
        int   k;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (sawIf) fetchPend = 1'b0;
            if (sawMem) memPend = 1'b0;
            if (!fetchPend && $urandom_range(0, 2) == 0) begin
                fetchPend = 1'b1;
                bus.if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            bus.if_req = fetchPend;
            bus.if_flush = ($urandom_range(0, 7) == 0);
            if (bus.if_flush && fetchPend) bus.if_addr = 32'($urandom_range(0, 63)) << 2;
            if (!memPend && $urandom_range(0, 3) == 0) begin
                memPend = 1'b1;
                k = $urandom_range(0, 4);
                bus.mem_rd    = (k < 2) || (k == 4);
                bus.mem_wr    = (k >= 2);
                bus.mem_addr  = 32'h40 + (32'($urandom_range(0, 63)) << 2);
                bus.mem_wdata = $urandom;
            end
            if (!memPend) begin bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; end
            sample();
            tests++;
            if (obs !== eVec) begin
                fails++; $display("FAIL rand_ctrl i%0d: got en/we/irdy/mrdy/stl/sts/stf=%b want %b", i, obs, eVec);
            end
            if (eRamEn) begin
                tests++;
                if (bus.ram_addr !== mAddr) begin
                    fails++; $display("FAIL rand_addr i%0d: got %h want %h", i, bus.ram_addr, mAddr);
                end
            end
            if (eRamWe) begin
                tests++;
                if (bus.ram_wdata !== mWdata) begin
                    fails++; $display("FAIL rand_wdata i%0d: got %h want %h", i, bus.ram_wdata, mWdata);
                end
            end
            tests++;
            if (bus.if_rdata !== mIfRd || bus.mem_rdata !== mMemRd) begin
                fails++; $display("FAIL rand_rdata i%0d: got if=%h mem=%h want %h/%h",
                                  i, bus.if_rdata, bus.mem_rdata, mIfRd, mMemRd);
            end
            sawIf  = eIfRdy;
            sawMem = eMemRdy;
            next_cyc();
        end
        rst = 1'b0; bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.if_flush = 1'b0;
        idle(L + 3);
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        next_cyc();
        test_reset();
        test_fetch();
        idle(1);
        test_fetch_load();
        idle(1);
        test_store();
        idle(1);
        test_flush();
        idle(1);
        test_reset_mid();
        idle(1);
        test_late_load();
        idle(1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
